// File: rtl/counter_pkg.sv
// Shared constants and mode encoding for the up/down modulo counter.
package counter_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STEP_W = 4;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_t;

endpackage : counter_pkg

// File: rtl/step_alu.sv
// Next-count and flag computation for one enabled counter cycle.
// Arithmetic runs one bit wider than the widest operand so limit+1 and
// count+step never truncate.
module step_alu
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              up_down,
  input  cnt_mode_t         mode,
  output logic [WIDTH-1:0]  next_count,
  output logic              ovf_c,
  output logic              unf_c,
  output logic              err_c
);

  localparam int unsigned EW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  logic [EW-1:0] cnt_x;
  logic [EW-1:0] lim_x;
  logic [EW-1:0] stp_x;
  logic [EW-1:0] span;
  logic [EW-1:0] sum;

  assign cnt_x = EW'(count);
  assign lim_x = EW'(limit);
  assign stp_x = EW'(step);
  assign span  = lim_x + EW'(1);
  assign sum   = cnt_x + stp_x;

  // Out-of-range count snaps to limit first; then illegal step, zero step, up, down.
  always_comb begin
    next_count = count;
    ovf_c      = 1'b0;
    unf_c      = 1'b0;
    err_c      = 1'b0;
    if (cnt_x > lim_x) begin
      next_count = limit;
    end else if (stp_x > span) begin
      err_c = 1'b1;
    end else if (stp_x == '0) begin
      next_count = count;
    end else if (up_down) begin
      if (sum <= lim_x) begin
        next_count = WIDTH'(sum);
      end else begin
        ovf_c      = 1'b1;
        next_count = (mode == MODE_SAT) ? limit : WIDTH'(sum - span);
      end
    end else begin
      if (stp_x <= cnt_x) begin
        next_count = WIDTH'(cnt_x - stp_x);
      end else begin
        unf_c      = 1'b1;
        next_count = (mode == MODE_SAT) ? '0 : WIDTH'(cnt_x + span - stp_x);
      end
    end
  end

endmodule : step_alu

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with runtime limit, variable step, wrap or saturate,
// and one-cycle overflow/underflow/illegal-step pulses.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              up_down,
  input  logic              sat_mode,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              ovf,
  output logic              unf,
  output logic              err,
  output logic              tc
);

  cnt_mode_t        mode;
  logic [WIDTH-1:0] alu_count;
  logic             alu_ovf;
  logic             alu_unf;
  logic             alu_err;
  logic [WIDTH-1:0] load_val;

  assign mode     = cnt_mode_t'(sat_mode);
  assign load_val = (data_in > limit) ? limit : data_in;

  step_alu #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step_alu (
    .count      (count),
    .limit      (limit),
    .step       (step),
    .up_down    (up_down),
    .mode       (mode),
    .next_count (alu_count),
    .ovf_c      (alu_ovf),
    .unf_c      (alu_unf),
    .err_c      (alu_err)
  );

  // Count and flag registers: reset > load > enable, flags cleared otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      err   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      err   <= 1'b0;
    end else if (en) begin
      count <= alu_count;
      ovf   <= alu_ovf;
      unf   <= alu_unf;
      err   <= alu_err;
    end else begin
      ovf   <= 1'b0;
      unf   <= 1'b0;
      err   <= 1'b0;
    end
  end

  // Terminal count follows the current direction without a register stage.
  assign tc = up_down ? (count == limit) : (count == '0);

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Randomized self-checking bench for updown_mod_counter (WIDTH=4, STEP_W=4).
module tb_updown_mod_counter;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              load;
  logic              up_down;
  logic              sat_mode;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  limit;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  count;
  logic              ovf;
  logic              unf;
  logic              err;
  logic              tc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int m_count = 0;
  int m_ovf   = 0;
  int m_unf   = 0;
  int m_err   = 0;

  updown_mod_counter #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .up_down  (up_down),
    .sat_mode (sat_mode),
    .data_in  (data_in),
    .limit    (limit),
    .step     (step),
    .count    (count),
    .ovf      (ovf),
    .unf      (unf),
    .err      (err),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural rules applied to plain integers.
  task automatic model_next(output int nc, output int o, output int u, output int e);
    int c, lim, st;
    c = m_count; lim = int'(limit); st = int'(step);
    nc = c; o = 0; u = 0; e = 0;
    if (load) begin
      nc = (int'(data_in) < lim) ? int'(data_in) : lim;
    end else if (en) begin
      if (c > lim)             nc = lim;
      else if (st > lim + 1)   e = 1;
      else if (st == 0)        nc = c;
      else if (up_down) begin
        if (c + st <= lim) nc = c + st;
        else begin o = 1; nc = sat_mode ? lim : (c + st) % (lim + 1); end
      end else begin
        if (st <= c) nc = c - st;
        else begin u = 1; nc = sat_mode ? 0 : (c - st) + (lim + 1); end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_tc;
    exp_tc = up_down ? int'(m_count == int'(limit)) : int'(m_count == 0);
    check({tag, ".count"}, int'(count), m_count);
    check({tag, ".ovf"},   int'(ovf),   m_ovf);
    check({tag, ".unf"},   int'(unf),   m_unf);
    check({tag, ".err"},   int'(err),   m_err);
    check({tag, ".tc"},    int'(tc),    exp_tc);
  endtask

  // One clock with current inputs, then compare against the model.
  task automatic run_cycle(input string tag);
    int nc, o, u, e;
    model_next(nc, o, u, e);
    @(posedge clk); #1;
    m_count = nc; m_ovf = o; m_unf = u; m_err = e;
    check_all(tag);
  endtask

  // Reset pulse between edges; outputs must clear before any edge arrives.
  task automatic async_reset(input string tag);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    m_count = 0; m_ovf = 0; m_unf = 0; m_err = 0;
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_in(input logic l, input logic e, input logic ud, input logic sm,
                        input int di, input int lim, input int st);
    load = l; en = e; up_down = ud; sat_mode = sm;
    data_in = WIDTH'(di); limit = WIDTH'(lim); step = STEP_W'(st);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 1, 0, 0, 9, 1);
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Up count with wrap at limit 9
    set_in(0, 1, 1, 0, 0, 9, 1);
    for (int i = 0; i < 11; i++) run_cycle("up_wrap");
    check("up_wrap.final", int'(count), 1);

    // Wrap-mode down underflow: 1 - 3 mod 10 -> 8
    set_in(1, 0, 0, 0, 1, 9, 3);
    run_cycle("load1");
    set_in(0, 1, 0, 0, 0, 9, 3);
    run_cycle("down_wrap");
    check("down_wrap.val", int'(count), 8);
    check("down_wrap.unf", int'(unf), 1);
    set_in(0, 0, 0, 0, 0, 9, 3);
    run_cycle("hold");

    // Saturating down clamp repeats the pulse
    set_in(1, 0, 0, 1, 2, 9, 3);
    run_cycle("load2");
    set_in(0, 1, 0, 1, 0, 9, 3);
    run_cycle("down_sat1");
    run_cycle("down_sat2");
    check("down_sat2.unf", int'(unf), 1);

    // Saturating up clamp
    set_in(0, 1, 1, 1, 0, 9, 7);
    for (int i = 0; i < 3; i++) run_cycle("up_sat");

    // Load clipped to limit, then illegal step
    set_in(1, 1, 1, 0, 12, 9, 1);
    run_cycle("load_clip");
    check("load_clip.val", int'(count), 9);
    set_in(0, 1, 1, 0, 0, 9, 11);
    run_cycle("bad_step");
    check("bad_step.err", int'(err), 1);

    // Step exactly limit+1 is legal and wraps to same value
    set_in(0, 1, 1, 0, 0, 9, 10);
    run_cycle("step_span");
    set_in(0, 1, 0, 0, 0, 9, 0);
    run_cycle("step_zero");

    // Asynchronous reset mid-operation at count 6
    set_in(1, 0, 1, 0, 6, 9, 1);
    run_cycle("load6");
    set_in(0, 0, 1, 0, 0, 9, 1);
    async_reset("async_rst");
    run_cycle("post_rst");

    // Limit lowered below the count
    set_in(1, 0, 1, 0, 7, 9, 1);
    run_cycle("load7");
    set_in(0, 1, 1, 0, 0, 3, 1);
    run_cycle("lim_drop");
    check("lim_drop.val", int'(count), 3);

    // Full-range limit exercises the widest arithmetic
    set_in(1, 0, 1, 0, 14, 15, 5);
    run_cycle("load14");
    set_in(0, 1, 1, 0, 0, 15, 5);
    run_cycle("full_up");
    set_in(0, 1, 0, 0, 0, 15, 9);
    run_cycle("full_down");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end
      set_in(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 8),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 9,
             int'($urandom_range(0, 15)));
      run_cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_updown_mod_counter

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the count, data_in and limit width in bits.
REQ-002 The block SHALL have parameter STEP_W, default 4, giving the step width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit, count enable.
REQ-006 The block SHALL have port load, input, 1 bit, synchronous load strobe.
REQ-007 The block SHALL have port up_down, input, 1 bit: 1 counts up, 0 counts down.
REQ-008 The block SHALL have port sat_mode, input, 1 bit: 0 wraps, 1 saturates.
REQ-009 The block SHALL have port data_in, input, WIDTH bits, load value.
REQ-010 The block SHALL have port limit, input, WIDTH bits, inclusive upper bound; the count range is 0..limit.
REQ-011 The block SHALL have port step, input, STEP_W bits, increment/decrement magnitude.
REQ-012 The block SHALL have port count, output, WIDTH bits, registered count value.
REQ-013 The block SHALL have port ovf, output, 1 bit, registered one-cycle pulse on upward wrap or clamp.
REQ-014 The block SHALL have port unf, output, 1 bit, registered one-cycle pulse on downward wrap or clamp.
REQ-015 The block SHALL have port err, output, 1 bit, registered one-cycle pulse on an illegal step.
REQ-016 The block SHALL have port tc, output, 1 bit, combinational terminal count: (up_down & count==limit) | (!up_down & count==0).

Function
REQ-017 Priority SHALL be rst > load > en; with en=0 and load=0, count holds and ovf/unf/err are 0.
REQ-018 On load, count SHALL become min(data_in, limit) at the next edge, and ovf/unf/err SHALL be 0.
REQ-019 Next-value arithmetic SHALL be done in WIDTH+1 bits so no intermediate sum truncates.
REQ-020 Up with count+step <= limit SHALL give count+step; ovf=0.
REQ-021 Up with count+step > limit SHALL give count+step-(limit+1) in wrap mode, or limit in saturate mode; ovf=1 for one cycle.
REQ-022 Down with step <= count SHALL give count-step; unf=0.
REQ-023 Down with step > count SHALL give count+(limit+1)-step in wrap mode, or 0 in saturate mode; unf=1 for one cycle.
REQ-024 An enabled cycle with step > limit+1 SHALL hold count and pulse err; ovf and unf stay 0.
REQ-025 An enabled cycle with step=0 SHALL hold count with no flags.
REQ-026 An enabled cycle with count > limit (limit lowered at runtime) SHALL set count to limit with no flags, overriding REQ-020..REQ-024.
REQ-027 Flags SHALL re-pulse on every enabled cycle that meets their condition, including repeated clamps at a bound.
REQ-028 Latency from input to count/flags SHALL be one clock cycle.

Reset
REQ-029 rst=1 SHALL immediately force count=0 and ovf=unf=err=0 without waiting for a clk edge, including mid-operation.
REQ-030 After rst deasserts, the first edge SHALL follow REQ-017..REQ-027 normally.

Structure
REQ-031 Package counter_pkg SHALL hold the default WIDTH and STEP_W constants and the enum cnt_mode_t {MODE_WRAP, MODE_SAT}.
REQ-032 The combinational next-value and flag logic SHALL be placed in sub-module step_alu; the top level holds registers, priority and tc.

Verification (WIDTH=4, STEP_W=4)
REQ-033 Count up with limit=9, step=1, wrap mode, en=1 from reset -> count 0..9 then 0; ovf pulses only on the 9->0 edge; tc=1 while count=9.
REQ-034 Count down in wrap mode, limit=9, count=1, step=3 -> count=8, unf=1 for one cycle.
REQ-035 Count down in saturate mode, count=2, step=3, two enabled cycles -> count 0 then 0; unf=1 on both cycles.
REQ-036 load=1, en=1, data_in=12, limit=9 -> count=9, no flags; step=11 on the next enabled cycle -> count holds at 9, err=1.
REQ-037 rst asserted between edges while count=6 -> count=0 immediately; lower limit to 3 while count=7, then enable -> count=3, no flags.
